// File: rtl/fetch_stage.sv
// RV32I IF stage: PC register, next-PC select and IF/ID pipeline register.
// Optional static BTFN branch prediction via `define FETCH_BTFN_PREDICT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pcF,
  input  logic [31:0] instrF,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pcD,
  output logic [31:0] instrD,
  output logic [31:0] pc_plus4D,
  output logic        validD,
  output logic        pred_takenD,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pcD_q, instrD_q, p4D_q;
  logic [31:0] cnt_q;
  logic        validD_q;
  logic        capture;
  logic        pred;

  assign pc_plus4 = pc_q + 32'd4;
  assign capture  = !flushD && !stallD;

`ifdef FETCH_BTFN_PREDICT_EN
  logic [31:0] bimm;
  logic [31:0] pred_target;
  logic        predD_q;

  // Backward conditional branches (negative B-immediate) are predicted taken.
  assign bimm = {{19{instrF[31]}}, instrF[31], instrF[7],
                 instrF[30:25], instrF[11:8], 1'b0};
  assign pred_target = pc_q + bimm;
  assign pred = (instrF[6:0] == 7'b1100011) && instrF[31]
                && !stallF && !redirect_valid;

  // Next-PC select: redirect > stall > prediction > sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid)
      pc_d = redirect_pc & ALIGN;
    else if (stallF)
      pc_d = pc_q;
    else if (pred)
      pc_d = pred_target & ALIGN;
  end

  // Prediction bit travels alongside the instruction into ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      predD_q <= 1'b0;
    else if (flushD)
      predD_q <= 1'b0;
    else if (!stallD)
      predD_q <= pred;
  end

  assign pred_takenD = predD_q;
`else
  assign pred = 1'b0;

  // Next-PC select: redirect > stall > sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid)
      pc_d = redirect_pc & ALIGN;
    else if (stallF)
      pc_d = pc_q;
  end

  assign pred_takenD = pred;
`endif

  // PC register; low two bits are kept clear so fetch stays word aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_q <= RESET_PC & ALIGN;
    else
      pc_q <= pc_d & ALIGN;
  end

  // IF/ID register: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcD_q    <= 32'd0;
      instrD_q <= NOP_INSTR;
      p4D_q    <= 32'd0;
      validD_q <= 1'b0;
    end else if (flushD) begin
      instrD_q <= NOP_INSTR;
      validD_q <= 1'b0;
    end else if (!stallD) begin
      pcD_q    <= pc_q;
      instrD_q <= instrF;
      p4D_q    <= pc_plus4;
      validD_q <= 1'b1;
    end
  end

  // Count of instructions accepted into ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= 32'd0;
    else if (capture)
      cnt_q <= cnt_q + 32'd1;
  end

  assign pcF         = pc_q;
  assign pcD         = pcD_q;
  assign instrD      = instrD_q;
  assign pc_plus4D   = p4D_q;
  assign validD      = validD_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes model expectations,
// a monitor pops and compares one entry per clock.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF, instrF;
  logic        stallF, stallD, flushD, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pcD, instrD, pc_plus4D, fetch_count;
  logic        validD, pred_takenD;

  typedef struct {
    logic [31:0] pcF, pcD, instrD, p4D, cnt;
    logic        vD, pD;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [31:0] m_pc, m_pcD, m_instrD, m_p4D, m_cnt;
  logic        m_vD, m_pD;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pcF(pcF), .instrF(instrF),
    .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pcD(pcD), .instrD(instrD), .pc_plus4D(pc_plus4D),
    .validD(validD), .pred_takenD(pred_takenD),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: backward beq at 0x20 and 0x1A0,
  // otherwise addi x0,x0,imm with an address-derived immediate.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h20 || a == 32'h1A0)
      return 32'hFE00_0EE3;
    return {a[13:2], 20'h00013};
  endfunction

  always_comb instrF = imem(pcF);

  function automatic exp_t snap();
    exp_t e;
    e.pcF = m_pc; e.pcD = m_pcD; e.instrD = m_instrD;
    e.p4D = m_p4D; e.cnt = m_cnt; e.vD = m_vD; e.pD = m_pD;
    return e;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    chk("pcF", pcF, e.pcF);
    chk("pcD", pcD, e.pcD);
    chk("instrD", instrD, e.instrD);
    chk("pc_plus4D", pc_plus4D, e.p4D);
    chk("fetch_count", fetch_count, e.cnt);
    chk("validD", {31'd0, validD}, {31'd0, e.vD});
    chk("pred_takenD", {31'd0, pred_takenD}, {31'd0, e.pD});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pcD = 32'h0; m_instrD = 32'h13;
    m_p4D = 32'h0; m_cnt = 32'h0; m_vD = 1'b0; m_pD = 1'b0;
  endtask

  // One clock of the reference behaviour, straight from the priority rules.
  task automatic model_step(input logic sf, input logic sd, input logic fl,
                            input logic rv, input logic [31:0] rpc);
    logic [31:0] ins, np, tgt;
    logic        pr;
    ins = imem(m_pc);
    pr  = 1'b0;
    tgt = m_pc + 32'd4;
`ifdef FETCH_BTFN_PREDICT_EN
    pr  = ins[6:0] == 7'h63 && ins[31] && !sf && !rv;
    tgt = m_pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                  ins[11:8], 1'b0};
`endif
    if (rv)      np = rpc;
    else if (sf) np = m_pc;
    else if (pr) np = tgt;
    else         np = m_pc + 32'd4;
    np[1:0] = 2'b00;
    if (fl) begin
      m_instrD = 32'h13; m_vD = 1'b0; m_pD = 1'b0;
    end else if (!sd) begin
      m_pcD = m_pc; m_instrD = ins; m_p4D = m_pc + 32'd4;
      m_vD = 1'b1; m_pD = pr; m_cnt = m_cnt + 32'd1;
    end
    m_pc = np;
  endtask

  task automatic step(input logic r, input logic sf, input logic sd,
                      input logic fl, input logic rv,
                      input logic [31:0] rpc);
    @(negedge clk);
    rst = r; stallF = sf; stallD = sd; flushD = fl;
    redirect_valid = rv; redirect_pc = rpc;
    if (r) begin
      model_reset();
      #1 cmp_all(snap());
    end else begin
      model_step(sf, sd, fl, rv, rpc);
    end
    q.push_back(snap());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) cmp_all(q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; stallF = 0; stallD = 0; flushD = 0;
    redirect_valid = 0; redirect_pc = 0;
    model_reset();
    #1 cmp_all(snap());
    step(1, 0, 0, 0, 0, 0);

    // Sequential fetch out of reset.
    step(0, 0, 0, 0, 0, 0);
    settle();
    chk("t1_pcD", pcD, 32'h0);
    chk("t1_validD", {31'd0, validD}, 32'd1);
    chk("t1_cnt", fetch_count, 32'd1);
    chk("t1_pcF", pcF, 32'h4);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    settle();
    chk("t2_pcF_pre", pcF, 32'h10);

    // Full stall for two cycles.
    repeat (2) step(0, 1, 1, 0, 0, 0);
    settle();
    chk("t2_pcF_hold", pcF, 32'h10);
    chk("t2_cnt_hold", fetch_count, 32'd4);
    chk("t2_pcD_hold", pcD, 32'hC);
    step(0, 0, 0, 0, 0, 0);
    settle();
    chk("t2_pcF_resume", pcF, 32'h14);

    // Redirect with flush and stall.
    step(0, 1, 0, 1, 1, 32'h43);
    settle();
    chk("t3_pcF", pcF, 32'h40);
    chk("t3_instrD", instrD, 32'h13);
    chk("t3_validD", {31'd0, validD}, 32'd0);

    // Wrap at the top of the address space.
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0);
    settle();
    chk("t4_pcF", pcF, 32'h0);
    chk("t4_pcD", pcD, 32'hFFFF_FFFC);
    chk("t4_p4D", pc_plus4D, 32'h0);

    // Asynchronous reset between edges.
    repeat (2) step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 cmp_all(snap());
    chk("t5_instrD", instrD, 32'h13);
    step(1, 0, 0, 0, 0, 0);

    // Backward branch at 0x20.
    step(0, 0, 0, 0, 1, 32'h20);
    step(0, 0, 0, 0, 0, 0);
    settle();
`ifdef FETCH_BTFN_PREDICT_EN
    chk("t6_pcF", pcF, 32'h1C);
    chk("t6_pred", {31'd0, pred_takenD}, 32'd1);
`else
    chk("t6_pcF", pcF, 32'h24);
    chk("t6_pred", {31'd0, pred_takenD}, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r, sf, sd, fl, rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 59) == 0);
      sf  = ($urandom_range(0, 3) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 5) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2:       rpc = 32'h1A0 | 32'($urandom_range(0, 3));
        default: rpc = 32'($urandom_range(0, 255));
      endcase
      step(r, sf, sd, fl, rv, rpc);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
